pitch_stabilizer: RTL and testbench

- Sits directly downstream of fft_pitch_detect and consumes its peak-bin stream (pitch_output_data/pitch_output_valid), in the fft_clk domain.
- Removes frame-to-frame jitter and spurious peaks. A bin is published only after CONFIRM consistent frames.
- The published bin holds through small wobble and drops to "no pitch" after a silence timeout.
- Output drives the HEX display and later note-mapping logic.

---
 rtl/pitch_stabilizer.sv | 160 ++++++++++++++++
 tb/tb_pitch_stabilizer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pitch_stabilizer.sv
// Debounces the FFT peak-bin stream into a stable published pitch.
// A bin locks after CONFIRM consistent frames and holds through small wobble. The lock drops after a silence timeout.
module pitch_stabilizer #(
  parameter int NSamples = 256,
  parameter int BIN_W    = $clog2(NSamples),
  parameter int CONFIRM  = 4,
  parameter int TOL      = 1,
  parameter int MIN_BIN  = 2,
  parameter int TIMEOUT  = 2000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BIN_W-1:0] pitch_in_data,
  input  logic             pitch_in_valid,
  output logic [BIN_W-1:0] stable_bin,
  output logic             stable_locked,
  output logic             stable_change,
  output logic [1:0]       state_dbg
);

  localparam int CW  = $clog2(CONFIRM + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int BW1 = BIN_W + 1;

  localparam logic [CW-1:0]  CONFIRM_C = CW'(CONFIRM);
  localparam logic [TW-1:0]  TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [BW1-1:0] LO_BIN    = BW1'(MIN_BIN);
  localparam logic [BW1-1:0] HI_BIN    = BW1'(NSamples / 2 - 1);
  localparam logic [BW1-1:0] TOL_C     = BW1'(TOL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAND      = 2'd1,
    LOCKED    = 2'd2,
    LOCK_CAND = 2'd3
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] cand;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;

  logic             in_band;
  logic             near_cand;
  logic             near_stable;
  logic [CW-1:0]    cnt_next;
  logic             confirm_hit;
  logic             lock_state;

  // Distance is taken one bit wider than the bin so it never wraps.
  function automatic logic near(input logic [BIN_W-1:0] a, input logic [BIN_W-1:0] b);
    logic [BW1-1:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, b} - {1'b0, a};
    return (d <= TOL_C);
  endfunction

  assign in_band     = ({1'b0, pitch_in_data} >= LO_BIN) && ({1'b0, pitch_in_data} <= HI_BIN);
  assign near_cand   = near(pitch_in_data, cand);
  assign near_stable = near(pitch_in_data, stable_bin);
  assign cnt_next    = (cnt >= CONFIRM_C) ? CONFIRM_C : cnt + CW'(1);
  assign confirm_hit = (cnt_next >= CONFIRM_C);
  assign lock_state  = (state == LOCKED) || (state == LOCK_CAND);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cand          <= '0;
      cnt           <= '0;
      timer         <= '0;
      stable_bin    <= '0;
      stable_locked <= 1'b0;
      stable_change <= 1'b0;
    end else begin
      stable_change <= 1'b0;
      if (lock_state && (timer != TIMEOUT_C)) timer <= timer + TW'(1);

      if (pitch_in_valid) begin
        case (state)
          IDLE: begin
            if (in_band) begin
              cand <= pitch_in_data;
              cnt  <= CW'(1);
              if (CONFIRM <= 1) begin
                state         <= LOCKED;
                stable_bin    <= pitch_in_data;
                stable_locked <= 1'b1;
                stable_change <= 1'b1;
                timer         <= '0;
              end else begin
                state <= CAND;
              end
            end
          end
          CAND: begin
            if (!in_band) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (near_cand) begin
              cnt <= cnt_next;
              if (confirm_hit) begin
                state         <= LOCKED;
                stable_bin    <= pitch_in_data;
                stable_locked <= 1'b1;
                stable_change <= 1'b1;
                timer         <= '0;
              end
            end else begin
              cand <= pitch_in_data;
              cnt  <= CW'(1);
            end
          end
          LOCKED: begin
            // Out-of-band frames are ignored and leave the timer running.
            if (in_band) begin
              if (near_stable) begin
                timer <= '0;
              end else begin
                state <= LOCK_CAND;
                cand  <= pitch_in_data;
                cnt   <= CW'(1);
              end
            end
          end
          LOCK_CAND: begin
            if (in_band) begin
              if (near_stable) begin
                state <= LOCKED;
                cnt   <= '0;
                timer <= '0;
              end else if (near_cand) begin
                cnt <= cnt_next;
                if (confirm_hit) begin
                  state         <= LOCKED;
                  stable_bin    <= pitch_in_data;
                  stable_change <= (pitch_in_data != stable_bin);
                  timer         <= '0;
                end
              end else begin
                cand <= pitch_in_data;
                cnt  <= CW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end else if (lock_state && (timer == TIMEOUT_C)) begin
        state         <= IDLE;
        cand          <= '0;
        cnt           <= '0;
        timer         <= '0;
        stable_bin    <= '0;
        stable_locked <= 1'b0;
        stable_change <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pitch_stabilizer.sv
// Directed bench for pitch_stabilizer; every stable_change pulse is matched against a queue of expected output values.
module tb_pitch_stabilizer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pitch_in_data = 8'd0;
  logic       pitch_in_valid = 1'b0;
  logic [7:0] stable_bin;
  logic       stable_locked;
  logic       stable_change;
  logic [1:0] state_dbg;

  int tests_run = 0;
  int fail_cnt = 0;
  logic [8:0] exp_q[$];

  pitch_stabilizer #(
    .NSamples(256), .CONFIRM(4), .TOL(1), .MIN_BIN(2), .TIMEOUT(1000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pitch_in_data(pitch_in_data),
    .pitch_in_valid(pitch_in_valid),
    .stable_bin(stable_bin),
    .stable_locked(stable_locked),
    .stable_change(stable_change),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: each observed pulse must match the oldest expected {locked, bin}
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset_n && stable_change === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fail_cnt++;
        $error("FAIL unexpected_pulse got=%0d/%0d exp=none", stable_locked, stable_bin);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_value", {23'd0, stable_locked, stable_bin}, {23'd0, e});
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [7:0] d);
    pitch_in_data  = d;
    pitch_in_valid = 1'b1;
    @(posedge clk);
    #1;
    pitch_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_change(input logic lk, input logic [7:0] b);
    exp_q.push_back({lk, b});
  endtask

  task automatic chk_q(input string tag);
    @(negedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic lock20(input string tag);
    send(8'd20); send(8'd20); send(8'd20);
    expect_change(1'b1, 8'd20);
    send(8'd20);
    chk({tag, "_bin"}, stable_bin, 20);
    chk_q({tag, "_q"});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_bin", stable_bin, 0);
    chk("rst_locked", stable_locked, 0);
    chk("rst_change", stable_change, 0);
    chk("rst_state", state_dbg, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: lock on the 4th consistent frame, value is that frame
    send(8'd20); send(8'd21); send(8'd20);
    chk("t1_prelock", stable_locked, 0);
    expect_change(1'b1, 8'd19);
    send(8'd19);
    chk("t1_bin", stable_bin, 19);
    chk("t1_locked", stable_locked, 1);
    chk_q("t1_q");

    // 2: broken run restarts the count
    do_reset();
    send(8'd20); send(8'd20); send(8'd35); send(8'd20); send(8'd20);
    chk("t2_nolock", stable_locked, 0);
    send(8'd20);
    chk("t2_nolock2", stable_locked, 0);
    expect_change(1'b1, 8'd20);
    send(8'd20);
    chk("t2_bin", stable_bin, 20);
    chk_q("t2_q");

    // 3: jitter within tolerance holds the lock
    send(8'd21); send(8'd19); send(8'd21); send(8'd20);
    chk("t3_bin", stable_bin, 20);
    chk("t3_locked", stable_locked, 1);
    chk_q("t3_q");

    // 4: switch to a new pitch, then an aborted switch
    send(8'd40); send(8'd40); send(8'd40);
    chk("t4_hold", stable_bin, 20);
    expect_change(1'b1, 8'd40);
    send(8'd40);
    chk("t4_bin", stable_bin, 40);
    chk_q("t4_q");
    send(8'd60); send(8'd60);
    chk("t4_lockcand", state_dbg, 3);
    send(8'd40);
    chk("t4_abort_bin", stable_bin, 40);
    chk("t4_abort_state", state_dbg, 2);
    chk_q("t4_abort_q");

    // 5: silence timeout, then a frame on the timeout cycle
    do_reset();
    lock20("t5_lock");
    idle(1000);
    chk("t5_before", stable_locked, 1);
    expect_change(1'b0, 8'd0);
    idle(1);
    chk("t5_locked", stable_locked, 0);
    chk("t5_bin", stable_bin, 0);
    chk_q("t5_q");
    lock20("t5b_lock");
    idle(1000);
    send(8'd20);
    chk("t5b_kept", stable_locked, 1);
    chk("t5b_bin", stable_bin, 20);
    chk_q("t5b_q");
    idle(1000);
    chk("t5b_restart", stable_locked, 1);
    expect_change(1'b0, 8'd0);
    idle(1);
    chk("t5b_drop", stable_locked, 0);
    chk_q("t5b_drop_q");

    // 6: band edges and asynchronous reset
    do_reset();
    send(8'd0); send(8'd1); send(8'd128); send(8'd200);
    chk("t6_oob_state", state_dbg, 0);
    chk("t6_oob_bin", stable_bin, 0);
    chk("t6_oob_locked", stable_locked, 0);
    send(8'd127);
    chk("t6_top_inband", state_dbg, 1);
    send(8'd20); send(8'd20); send(8'd20);
    chk("t6_cand", state_dbg, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_state", state_dbg, 0);
    chk("t6_async_locked", stable_locked, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(8'd20); send(8'd20); send(8'd20);
    chk("t6_nolock", stable_locked, 0);
    expect_change(1'b1, 8'd20);
    send(8'd20);
    chk("t6_relock", stable_locked, 1);
    chk_q("t6_q");
    reset_n = 1'b0;
    #1;
    chk("t6_async_unlock", stable_locked, 0);
    chk("t6_async_bin", stable_bin, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Lowest in-band bin locks
    send(8'd1); send(8'd2); send(8'd3); send(8'd2);
    expect_change(1'b1, 8'd2);
    send(8'd2);
    chk("min_bin", stable_bin, 2);
    chk_q("min_bin_q");

    idle(3);
    chk("final_q", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
